ifetch_ctrl: RTL and testbench

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/ifetch_fifo.sv | 78 +++++++
 rtl/ifetch_ctrl.sv | 113 +++++++++++
 tb/tb_ifetch_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller and its bench.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [31:0] IMEM_LIMIT = 32'h0000_2000;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    // Misaligned or beyond the instruction memory window.
    function automatic logic addr_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc >= IMEM_LIMIT);
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small prefetch buffer: register entries, combinational head, flush clears all.
module ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [WIDTH-1:0] entry_data [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty && !flush;
    // A push at full is only legal when the head leaves in the same cycle.
    assign push_ok = push && !flush && (!full || pop_ok);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    data_reg <= push_data;
                end
            end
            assign entry_data[gi] = data_reg;
        end
    endgenerate

    assign head_data = entry_data[rd_ptr_reg];
    assign count     = count_reg;

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (push_ok && !pop_ok) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: BOOT/RUN/HALT sequencing over a prefetch buffer.
// Define IFETCH_FAULT_EN to carry a per-entry address fault flag to decode.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_pc_o,
    output logic [31:0] inst_data_o,
    output logic        inst_fault_o,
    output logic        halted_o
);

`ifdef IFETCH_FAULT_EN
    localparam int ENTRY_W = 65;
`else
    localparam int ENTRY_W = 64;
`endif
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t             state_reg;
    state_t             state_next;
    logic [31:0]        fetch_pc_reg;
    logic [31:0]        fetch_pc_next;
    logic               fetch_en;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_BOOT;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN:  if (halt_i)  state_next = ST_HALT;
            ST_HALT: if (!halt_i) state_next = ST_RUN;
            default: state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        fetch_en = (state_reg == ST_RUN);
        halted_o = (state_reg == ST_HALT) && fifo_empty;
    end

    // A redirect wins over both the handshake and the fetch in its cycle.
    assign fifo_pop  = inst_valid_o && inst_ready_i && !redirect_valid_i;
    assign fifo_push = fetch_en && !redirect_valid_i && (!fifo_full || fifo_pop);

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        if (redirect_valid_i) begin
            fetch_pc_next = redirect_pc_i;
        end else if (fifo_push) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_pc_reg <= RESET_PC;
        else     fetch_pc_reg <= fetch_pc_next;
    end

    assign imem_addr_o = fetch_pc_reg;

`ifdef IFETCH_FAULT_EN
    assign push_data    = {addr_fault(fetch_pc_reg), fetch_pc_reg, imem_rdata_i};
    assign inst_fault_o = inst_valid_o && head_data[64];
`else
    assign push_data    = {fetch_pc_reg, imem_rdata_i};
    assign inst_fault_o = 1'b0;
`endif

    ifetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (redirect_valid_i),
        .push_data (push_data),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Head fields are masked while empty so reset shows zeros without a clock.
    assign inst_valid_o = (fifo_count != '0);
    assign inst_pc_o    = inst_valid_o ? head_data[63:32] : 32'd0;
    assign inst_data_o  = inst_valid_o ? head_data[31:0]  : 32'd0;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: expected fetches queued at stimulus, checked on handshake.
module tb_ifetch_ctrl;
    import ifetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        inst_ready = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_fault;
    logic        halted;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ NOP;
    endfunction

    function automatic logic exp_fault(input logic [31:0] pc);
`ifdef IFETCH_FAULT_EN
        return (pc[1:0] != 2'b00) || (pc[31:13] != 19'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void expect_pc(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.data  = rom_word(pc);
        e.fault = exp_fault(pc);
        exp_q.push_back(e);
    endfunction

    assign imem_rdata = rom_word(imem_addr);

    ifetch_ctrl #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .halt_i           (halt),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .imem_addr_o      (imem_addr),
        .imem_rdata_i     (imem_rdata),
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (inst_ready),
        .inst_pc_o        (inst_pc),
        .inst_data_o      (inst_data),
        .inst_fault_o     (inst_fault),
        .halted_o         (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT one cycle after BOOT, in RUN with an empty buffer.
    task automatic do_reset();
        rst = 1'b1;
        halt = 1'b0;
        redirect_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        step();
    endtask

    task automatic test_reset();
        exp_t e;
        inst_ready = 1'b1;
        step();
        step();
        n_cmp++;
        if ({inst_valid, inst_pc, inst_data, inst_fault, halted} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b pc=%h data=%h fault=%b halted=%b, need all zero",
                     inst_valid, inst_pc, inst_data, inst_fault, halted);
        end
        n_cmp++;
        if (imem_addr !== RESET_PC) begin
            n_err++;
            $display("FAIL reset_addr: got %h, need %h", imem_addr, RESET_PC);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL boot_valid: got %b, need 0", inst_valid);
        end
        step();
        n_cmp++;
        if (inst_valid !== 1'b0 || imem_addr !== RESET_PC) begin
            n_err++;
            $display("FAIL boot_nofetch: got valid=%b addr=%h, need valid=0 addr=%h",
                     inst_valid, imem_addr, RESET_PC);
        end
        expect_pc(RESET_PC);
        expect_pc(RESET_PC + 32'd4);
        expect_pc(RESET_PC + 32'd8);
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (!inst_valid || exp_q.size() == 0) begin
                n_err++;
                $display("FAIL reset_stream: cycle %0d got valid=%b, need 1", i, inst_valid);
            end else begin
                e = exp_q.pop_front();
                if ({inst_pc, inst_data, inst_fault} !== {e.pc, e.data, e.fault}) begin
                    n_err++;
                    $display("FAIL reset_stream: got pc=%h data=%h fault=%b, need pc=%h data=%h fault=%b",
                             inst_pc, inst_data, inst_fault, e.pc, e.data, e.fault);
                end else begin
                    $display("ok reset_stream pc=%h data=%h", inst_pc, inst_data);
                end
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        do_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (!inst_valid || inst_pc !== RESET_PC || inst_data !== rom_word(RESET_PC) ||
                imem_addr !== ((i == 0) ? RESET_PC + 32'd4 : RESET_PC + 32'd8)) begin
                n_err++;
                $display("FAIL stall_hold: cycle %0d got valid=%b pc=%h addr=%h, need valid=1 pc=%h addr=%h",
                         i, inst_valid, inst_pc, imem_addr, RESET_PC,
                         (i == 0) ? RESET_PC + 32'd4 : RESET_PC + 32'd8);
            end
        end
        expect_pc(RESET_PC);
        expect_pc(RESET_PC + 32'd4);
        expect_pc(RESET_PC + 32'd8);
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (!inst_valid || exp_q.size() == 0) begin
                n_err++;
                $display("FAIL stall_release: cycle %0d got valid=%b, need 1", i, inst_valid);
            end else begin
                e = exp_q.pop_front();
                if ({inst_pc, inst_data, inst_fault} !== {e.pc, e.data, e.fault}) begin
                    n_err++;
                    $display("FAIL stall_release: got pc=%h data=%h fault=%b, need pc=%h data=%h fault=%b",
                             inst_pc, inst_data, inst_fault, e.pc, e.data, e.fault);
                end else begin
                    $display("ok stall_release pc=%h data=%h", inst_pc, inst_data);
                end
            end
            step();
        end
    endtask

    task automatic test_redirect();
        exp_t e;
        do_reset();
        inst_ready = 1'b0;
        repeat (3) step();
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        exp_q.delete();
        expect_pc(32'h0000_0100);
        expect_pc(32'h0000_0104);
        expect_pc(32'h0000_0108);
        step();
        redirect_valid = 1'b0;
        n_cmp++;
        if (inst_valid !== 1'b0 || imem_addr !== 32'h0000_0100) begin
            n_err++;
            $display("FAIL redirect_bubble: got valid=%b addr=%h, need valid=0 addr=00000100",
                     inst_valid, imem_addr);
        end
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
            if (inst_valid && inst_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({inst_pc, inst_data, inst_fault} !== {e.pc, e.data, e.fault}) begin
                    n_err++;
                    $display("FAIL redirect_stream: got pc=%h data=%h fault=%b, need pc=%h data=%h fault=%b",
                             inst_pc, inst_data, inst_fault, e.pc, e.data, e.fault);
                end else begin
                    $display("ok redirect_stream pc=%h data=%h", inst_pc, inst_data);
                end
            end
            step();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL redirect_timeout: got %0d undelivered, need 0", exp_q.size());
        end
    endtask

    task automatic test_halt();
        exp_t e;
        do_reset();
        inst_ready = 1'b0;
        repeat (3) step();
        halt = 1'b1;
        step();
        n_cmp++;
        if (halted !== 1'b0 || inst_valid !== 1'b1 || imem_addr !== RESET_PC + 32'd8) begin
            n_err++;
            $display("FAIL halt_enter: got halted=%b valid=%b addr=%h, need halted=0 valid=1 addr=%h",
                     halted, inst_valid, imem_addr, RESET_PC + 32'd8);
        end
        inst_ready = 1'b1;
        expect_pc(RESET_PC);
        expect_pc(RESET_PC + 32'd4);
        for (int i = 0; i < 6 && exp_q.size() != 0; i++) begin
            if (inst_valid && inst_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({inst_pc, inst_data, inst_fault} !== {e.pc, e.data, e.fault}) begin
                    n_err++;
                    $display("FAIL halt_drain: got pc=%h data=%h fault=%b, need pc=%h data=%h fault=%b",
                             inst_pc, inst_data, inst_fault, e.pc, e.data, e.fault);
                end else begin
                    $display("ok halt_drain pc=%h data=%h", inst_pc, inst_data);
                end
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (halted !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== RESET_PC + 32'd8) begin
                n_err++;
                $display("FAIL halt_frozen: cycle %0d got halted=%b valid=%b addr=%h, need halted=1 valid=0 addr=%h",
                         i, halted, inst_valid, imem_addr, RESET_PC + 32'd8);
            end
            step();
        end
        halt = 1'b0;
        expect_pc(RESET_PC + 32'd8);
        expect_pc(RESET_PC + 32'd12);
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
            if (inst_valid && inst_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({inst_pc, inst_data, inst_fault} !== {e.pc, e.data, e.fault}) begin
                    n_err++;
                    $display("FAIL halt_resume: got pc=%h data=%h fault=%b, need pc=%h data=%h fault=%b",
                             inst_pc, inst_data, inst_fault, e.pc, e.data, e.fault);
                end else begin
                    $display("ok halt_resume pc=%h data=%h", inst_pc, inst_data);
                end
            end
            step();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL halt_timeout: got %0d undelivered, need 0", exp_q.size());
        end
    endtask

    task automatic test_fault();
        exp_t        e;
        logic [31:0] targets [2];
        targets[0] = 32'h0000_1FF8;
        targets[1] = 32'h0000_1FFE;
        do_reset();
        inst_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            redirect_valid = 1'b1;
            redirect_pc = targets[t];
            exp_q.delete();
            expect_pc(targets[t]);
            if (t == 0) begin
                expect_pc(32'h0000_1FFC);
                expect_pc(32'h0000_2000);
                expect_pc(32'h0000_2004);
            end
            step();
            redirect_valid = 1'b0;
            for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
                if (inst_valid && inst_ready) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if ({inst_pc, inst_data, inst_fault} !== {e.pc, e.data, e.fault}) begin
                        n_err++;
                        $display("FAIL fault_flag: got pc=%h data=%h fault=%b, need pc=%h data=%h fault=%b",
                                 inst_pc, inst_data, inst_fault, e.pc, e.data, e.fault);
                    end else begin
                        $display("ok fault_flag pc=%h fault=%b", inst_pc, inst_fault);
                    end
                end
                step();
            end
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_err++;
                $display("FAIL fault_timeout: got %0d undelivered, need 0", exp_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        inst_ready = 1'b1;
        repeat (5) step();
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_pc !== RESET_PC + 32'h10) begin
            n_err++;
            $display("FAIL midrst_pre: got valid=%b pc=%h, need valid=1 pc=%h",
                     inst_valid, inst_pc, RESET_PC + 32'h10);
        end
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({inst_valid, inst_pc, inst_data, inst_fault, halted} !== 66'd0 || imem_addr !== RESET_PC) begin
            n_err++;
            $display("FAIL midrst_async: got valid=%b pc=%h data=%h fault=%b halted=%b addr=%h, need zeros addr=%h",
                     inst_valid, inst_pc, inst_data, inst_fault, halted, imem_addr, RESET_PC);
        end
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        step();
        expect_pc(RESET_PC);
        expect_pc(RESET_PC + 32'd4);
        for (int i = 0; i < 6 && exp_q.size() != 0; i++) begin
            if (inst_valid && inst_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({inst_pc, inst_data, inst_fault} !== {e.pc, e.data, e.fault}) begin
                    n_err++;
                    $display("FAIL midrst_stream: got pc=%h data=%h fault=%b, need pc=%h data=%h fault=%b",
                             inst_pc, inst_data, inst_fault, e.pc, e.data, e.fault);
                end else begin
                    $display("ok midrst_stream pc=%h data=%h", inst_pc, inst_data);
                end
            end
            step();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL midrst_timeout: got %0d undelivered, need 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_halt();
        test_fault();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, need finish", $time);
        $fatal(1);
    end

endmodule
